lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the decode stage in the NPC core. It consumes the decoder's `load_inst`, `store_mask`, and `store_data` encodings plus the ALU result, and performs one data-memory access over a valid/ready request/response interface. It aligns store data and byte masks, and extracts and sign- or zero-extends load data. It then hands the register write-back triple (`w_regW`, `w_regAddr`, `w_regData`) to the register-file write port.

## Interface
- `REG_ADDR_WIDTH`, 5, register address width.
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width. Only 32 is supported.
- `clk`  in  1  clock. All state changes on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-high, single clock.**
- `in_valid`  in  1  upstream holds a valid operation.
- `in_ready`  out  1  LSU can accept an operation.
- `alu_result`  in  DATA_WIDTH  effective address for loads/stores; write-back value otherwise.
- `load_inst`  in  3  000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu. 110 and 111 are treated as none.
- `store_mask`  in  4  0000 none, 0001 sb, 0011 sh, 1111 sw. Other values are treated as none.
- `store_data`  in  DATA_WIDTH  unaligned store source (rs2).
- `d_regW`  in  1  decoded register-write enable.
- `d_regAddr`  in  REG_ADDR_WIDTH  decoded rd.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  ADDR_WIDTH  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_req_wen`  out  1  1 for store, 0 for load.
- `mem_req_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `mem_req_wmask`  out  4  lane-shifted byte enables. 0000 on loads.
- `mem_resp_valid`  in  1  response valid, for both load data and store ack.
- `mem_resp_rdata`  in  DATA_WIDTH  full aligned word.
- `out_valid`  out  1  write-back triple valid.
- `out_ready`  in  1  downstream accepts.
- `w_regW`  out  1  register write enable. Qualified by `out_valid`.
- `w_regAddr`  out  REG_ADDR_WIDTH  destination register.
- `w_regData`  out  DATA_WIDTH  write-back data.
- `misalign`  out  1  current result is a misaligned access. Qualified by `out_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Accept: in IDLE, `in_ready`=1. If `in_valid` is also high, register all inputs. A load takes priority if both `load_inst` and `store_mask` are nonzero.
- Misalignment check:
  - lh/lhu/sh with `addr[0]`=1 is misaligned.
  - lw/sw with `addr[1:0]`≠0 is misaligned.
  - On misalignment: go to DONE, issue no memory request, set `misalign`=1, force `w_regW`=0.
- Non-memory operation (none/none): go to DONE. `w_regData`=`alu_result`, `w_regW`=`d_regW`.
- Memory operation: go to REQ.
- REQ: `mem_req_*` are driven from registered values and held stable. When `mem_req_valid`&&`mem_req_ready`, go to WAIT.
- WAIT: when `mem_resp_valid`, capture data and go to DONE.
- Store data and mask: with `off = addr[1:0]`:
  - `wdata = store_data << (8*off)`.
  - `wmask = store_mask << off`, truncated to 4 bits.
- Load data: `sh = mem_resp_rdata >> (8*off)`.
  - lb: sext `sh[7:0]`; lbu: zext `sh[7:0]`.
  - lh: sext `sh[15:0]`; lhu: zext `sh[15:0]`.
  - lw: `mem_resp_rdata`.
- Write-back by operation:
  - Load: `w_regW`=`d_regW`.
  - Store: `w_regW`=0, `w_regData`=0.
- DONE: `out_valid`=1 and outputs are held until `out_ready`, then go to IDLE.
- Output rules: `w_regAddr` is always the registered `d_regAddr`. `w_regW` is 0 whenever `d_regAddr`=0.
- `mem_resp_valid` outside WAIT is ignored.

## Timing
- Reset values: `in_ready`=1, and every other output is 0, including `mem_req_addr`, `mem_req_wdata`, `mem_req_wmask`, and `w_regData`. `rst` overrides every other input in the same edge.
- Reset mid-operation (REQ/WAIT/DONE): return to IDLE next cycle and abandon the transaction. A late `mem_resp_valid` is ignored.
- Non-memory or misaligned operation: accepted at edge N, `out_valid` high during cycle N+1.
- Memory operation:
  - Accepted at edge N; `mem_req_valid` high from cycle N+1.
  - If `mem_req_ready`=1 at N+1, WAIT from N+2.
  - Response seen in cycle N+2 gives `out_valid` in cycle N+3. This is the minimum latency: 3 cycles accept-to-result.
- `mem_req_ready` stalls: request fields stay constant for every stalled cycle.
- Response: arrives no earlier than the cycle after the request handshake. A response coinciding with the request handshake cycle is not sampled.
- `out_ready` low: DONE holds and `in_ready` stays 0. At most one operation is ever in flight.
- DONE→IDLE on the handshake edge; a new operation can be accepted in the next cycle.

## Test plan
- Non-memory op, `alu_result`=0x1234, `d_regW`=1, `d_regAddr`=5 -> one cycle later `out_valid`=1, `w_regData`=0x1234, `w_regW`=1, `w_regAddr`=5, no `mem_req_valid`.
- sb, addr 0x80000003, `store_data`=0xAB -> `mem_req_addr`=0x80000000, `wmask`=1000, `wdata`=0xAB000000, `wen`=1. After ack, `w_regW`=0.
- lb/lbu at addr 0x80000001, `rdata`=0x1122_80FF -> lb gives 0xFFFFFF80, lbu gives 0x00000080. lh at addr 0x80000002 gives 0x00001122.
- lw at addr 0x80000002 -> no memory request, `misalign`=1, `w_regW`=0, `out_valid` next cycle.
- lw with `mem_req_ready` low for 3 cycles, response 2 cycles later, `out_ready` low for 2 cycles -> request fields stable throughout, `in_ready`=0 until the DONE handshake, data=`rdata`.
- `rst` asserted in WAIT, then `mem_resp_valid` pulsed after reset -> IDLE, all outputs at reset values, stray response ignored, next lw completes normally.

Source files
------------

// File: rtl/lsu.sv
// lsu -- load/store unit between decode and register-file write-back.
//
// Accepts one decoded operation at a time, performs at most one data-memory
// access over a valid/ready request port, and returns the write-back triple.
// Store data and byte enables are shifted into their byte lanes. Load data is
// extracted from the aligned response word and sign- or zero-extended.
// Misaligned halfword/word accesses never reach memory. They complete
// immediately with misalign set and the register write suppressed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream operation handshake
//   alu_result          effective address (memory ops) or write-back value
//   load_inst           000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu
//   store_mask          0000 none, 0001 sb, 0011 sh, 1111 sw
//   store_data          unaligned store source (rs2)
//   d_regW, d_regAddr   decoded destination register write enable / index
//   mem_req_*           word-aligned memory request (addr, wen, wdata, wmask)
//   mem_resp_*          memory response (load data or store ack)
//   out_valid/out_ready write-back handshake
//   w_regW, w_regAddr, w_regData  register-file write port
//   misalign            result belongs to a misaligned access
module lsu #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [2:0]                load_inst,
  input  logic [3:0]                store_mask,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic                      d_regW,
  input  logic [REG_ADDR_WIDTH-1:0] d_regAddr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic                      mem_req_wen,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  output logic [3:0]                mem_req_wmask,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      w_regW,
  output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
  output logic [DATA_WIDTH-1:0]     w_regData,
  output logic                      misalign
);

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam logic [3:0] SM_B = 4'b0001;
  localparam logic [3:0] SM_H = 4'b0011;
  localparam logic [3:0] SM_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Lane-shift store data by the byte offset.
  function automatic logic [DATA_WIDTH-1:0] align_wdata(
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            off
  );
    return d << {off, 3'b000};
  endfunction

  // Lane-shift byte enables; bits pushed past lane 3 are dropped.
  function automatic logic [3:0] align_wmask(
    input logic [3:0] m,
    input logic [1:0] off
  );
    return m << off;
  endfunction

  // Extract and extend the addressed byte/halfword from the aligned word.
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [2:0]            op,
    input logic [1:0]            off,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic [DATA_WIDTH-1:0]        sh;
    logic signed [7:0]            b;
    logic signed [15:0]           h;
    logic signed [DATA_WIDTH-1:0] r;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      LD_LB:   r = DATA_WIDTH'(b);
      LD_LBU:  r = DATA_WIDTH'(sh[7:0]);
      LD_LH:   r = DATA_WIDTH'(h);
      LD_LHU:  r = DATA_WIDTH'(sh[15:0]);
      LD_LW:   r = rdata;
      default: r = '0;
    endcase
    return $unsigned(r);
  endfunction

  // Decode of the incoming operation (valid only while accepting in IDLE).
  logic       is_load_in, is_store_in, is_mem_in;
  logic       half_in, word_in, mis_in, accept;
  logic [1:0] off_in;

  always_comb begin
    off_in      = alu_result[1:0];
    is_load_in  = (load_inst != LD_NONE) && (load_inst <= LD_LHU);
    is_store_in = !is_load_in &&
                  ((store_mask == SM_B) || (store_mask == SM_H) || (store_mask == SM_W));
    is_mem_in   = is_load_in || is_store_in;
    half_in     = is_load_in ? ((load_inst == LD_LH) || (load_inst == LD_LHU))
                             : (is_store_in && (store_mask == SM_H));
    word_in     = is_load_in ? (load_inst == LD_LW)
                             : (is_store_in && (store_mask == SM_W));
    mis_in      = (half_in && off_in[0]) || (word_in && (off_in != 2'b00));
    accept      = (state == IDLE) && in_valid;
  end

  // Accepted-operation registers (_p1) and write-back result registers (_p2).
  logic [ADDR_WIDTH-1:0]     addr_p1;
  logic [2:0]                load_p1;
  logic                      is_load_p1;
  logic                      regw_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic                      wen_p1;
  logic [3:0]                wmask_p1;
  logic [DATA_WIDTH-1:0]     wdata_p1;
  logic                      mis_p2;
  logic                      regw_p2;
  logic [DATA_WIDTH-1:0]     data_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (is_mem_in && !mis_in) ? REQ : DONE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: capture the operation on accept; stage p2: result on completion.
  // Data registers are cleared by reset because every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1    <= '0;
      load_p1    <= LD_NONE;
      is_load_p1 <= 1'b0;
      regw_p1    <= 1'b0;
      rd_p1      <= '0;
      wen_p1     <= 1'b0;
      wmask_p1   <= 4'b0000;
      wdata_p1   <= '0;
      mis_p2     <= 1'b0;
      regw_p2    <= 1'b0;
      data_p2    <= '0;
    end else if (accept) begin
      addr_p1    <= alu_result[ADDR_WIDTH-1:0];
      load_p1    <= load_inst;
      is_load_p1 <= is_load_in;
      regw_p1    <= d_regW && (d_regAddr != '0);
      rd_p1      <= d_regAddr;
      wen_p1     <= is_store_in && !mis_in;
      wmask_p1   <= (is_store_in && !mis_in) ? align_wmask(store_mask, off_in) : 4'b0000;
      wdata_p1   <= (is_store_in && !mis_in) ? align_wdata(store_data, off_in) : '0;
      mis_p2     <= mis_in;
      // Non-memory ops complete right away with the ALU value; memory ops
      // overwrite these on response, misaligned ones keep zeros.
      regw_p2    <= !is_mem_in && d_regW && (d_regAddr != '0);
      data_p2    <= is_mem_in ? '0 : alu_result;
    end else if ((state == WAIT) && mem_resp_valid) begin
      regw_p2    <= is_load_p1 && regw_p1;
      data_p2    <= is_load_p1 ? load_ext(load_p1, addr_p1[1:0], mem_resp_rdata) : '0;
    end
  end

  always_comb begin
    mem_req_addr  = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
    mem_req_wen   = wen_p1;
    mem_req_wdata = wdata_p1;
    mem_req_wmask = wmask_p1;
    w_regW        = regw_p2;
    w_regAddr     = rd_p1;
    w_regData     = data_p2;
    misalign      = mis_p2;
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [2:0]  load_inst;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic        d_regW;
  logic [4:0]  d_regAddr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        w_regW;
  logic [4:0]  w_regAddr;
  logic [31:0] w_regData;
  logic        misalign;

  lsu #(.REG_ADDR_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .load_inst(load_inst), .store_mask(store_mask),
    .store_data(store_data), .d_regW(d_regW), .d_regAddr(d_regAddr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_regW(w_regW), .w_regAddr(w_regAddr), .w_regData(w_regData),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] alu;
    logic [2:0]  ld;
    logic [3:0]  sm;
    logic [31:0] sd;
    logic        regw;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mem;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic        e_mis;
    logic        e_regw;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add_vec(
    input logic [31:0] alu, input logic [2:0] ld, input logic [3:0] sm,
    input logic [31:0] sd, input logic regw, input logic [4:0] rd,
    input logic [31:0] rdata, input logic mem, input logic [31:0] e_addr,
    input logic e_wen, input logic [3:0] e_wmask, input logic [31:0] e_wdata,
    input logic e_mis, input logic e_regw, input logic chk_data,
    input logic [31:0] e_data);
    vec_t v;
    v.alu = alu; v.ld = ld; v.sm = sm; v.sd = sd; v.regw = regw; v.rd = rd;
    v.rdata = rdata; v.mem = mem; v.e_addr = e_addr; v.e_wen = e_wen;
    v.e_wmask = e_wmask; v.e_wdata = e_wdata; v.e_mis = e_mis;
    v.e_regw = e_regw; v.chk_data = chk_data; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [2:0] ld,
                          input logic [3:0] sm, input logic [31:0] sd,
                          input logic regw, input logic [4:0] rd);
    in_valid = 1'b1; alu_result = alu; load_inst = ld; store_mask = sm;
    store_data = sd; d_regW = regw; d_regAddr = rd;
    tick();
    in_valid = 1'b0; alu_result = '0; load_inst = '0; store_mask = '0;
    store_data = '0; d_regW = 1'b0; d_regAddr = '0;
  endtask

  task automatic chk_reset(input string tag);
    chkb({tag, "_in_ready"}, in_ready, 1'b1);
    chkb({tag, "_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
    chkb({tag, "_req_wen"}, mem_req_wen, 1'b0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 32'h0);
    chk({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'h0);
    chkb({tag, "_out_valid"}, out_valid, 1'b0);
    chkb({tag, "_regW"}, w_regW, 1'b0);
    chk({tag, "_regAddr"}, 32'(w_regAddr), 32'h0);
    chk({tag, "_regData"}, w_regData, 32'h0);
    chkb({tag, "_misalign"}, misalign, 1'b0);
  endtask

  // Entry: just after an edge, DUT idle. Exit: same, DUT idle again.
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    chkb({p, "_in_ready"}, in_ready, 1'b1);
    drive_op(v.alu, v.ld, v.sm, v.sd, v.regw, v.rd);
    if (v.mem) begin
      chkb({p, "_req_valid"}, mem_req_valid, 1'b1);
      chkb({p, "_early_out"}, out_valid, 1'b0);
      chk({p, "_req_addr"}, mem_req_addr, v.e_addr);
      chkb({p, "_req_wen"}, mem_req_wen, v.e_wen);
      chk({p, "_req_wmask"}, 32'(mem_req_wmask), 32'(v.e_wmask));
      chk({p, "_req_wdata"}, mem_req_wdata, v.e_wdata);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chkb({p, "_req_drop"}, mem_req_valid, 1'b0);
      mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata;
      tick();
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    end else begin
      chkb({p, "_no_req"}, mem_req_valid, 1'b0);
    end
    chkb({p, "_out_valid"}, out_valid, 1'b1);
    chkb({p, "_misalign"}, misalign, v.e_mis);
    chkb({p, "_regW"}, w_regW, v.e_regw);
    chk({p, "_regAddr"}, 32'(w_regAddr), 32'(v.rd));
    if (v.chk_data) chk({p, "_regData"}, w_regData, v.e_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb({p, "_out_drop"}, out_valid, 1'b0);
    chkb({p, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // alu, ld, sm, sd, regw, rd, rdata | mem, addr, wen, wmask, wdata, mis, regw, chkdata, data
    add_vec(32'h0000_1234, 3'd0, 4'b0000, 32'h0, 1, 5'd5, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_1234);
    add_vec(32'h0000_0055, 3'd0, 4'b0000, 32'h0, 1, 5'd0, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 0, 0, 1, 32'h0000_0055);
    add_vec(32'h8000_0003, 3'd0, 4'b0001, 32'h0000_00AB, 1, 5'd7, 32'h0,
            1, 32'h8000_0000, 1, 4'b1000, 32'hAB00_0000, 0, 0, 1, 32'h0);
    add_vec(32'h8000_0001, 3'd1, 4'b0000, 32'h0, 1, 5'd10, 32'h1122_80FF,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'hFFFF_FF80);
    add_vec(32'h8000_0001, 3'd4, 4'b0000, 32'h0, 1, 5'd11, 32'h1122_80FF,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_0080);
    add_vec(32'h8000_0002, 3'd2, 4'b0000, 32'h0, 1, 5'd12, 32'h1122_80FF,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_1122);
    add_vec(32'h8000_0000, 3'd2, 4'b0000, 32'h0, 1, 5'd13, 32'h0000_8001,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'hFFFF_8001);
    add_vec(32'h8000_0002, 3'd5, 4'b0000, 32'h0, 1, 5'd14, 32'h9988_0000,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_9988);
    add_vec(32'h8000_0004, 3'd3, 4'b0000, 32'h0, 1, 5'd15, 32'hDEAD_BEEF,
            1, 32'h8000_0004, 0, 4'b0000, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
    add_vec(32'h8000_0002, 3'd0, 4'b0011, 32'h1234_ABCD, 0, 5'd1, 32'h0,
            1, 32'h8000_0000, 1, 4'b1100, 32'hABCD_0000, 0, 0, 1, 32'h0);
    add_vec(32'h8000_0008, 3'd0, 4'b1111, 32'hCAFE_F00D, 1, 5'd2, 32'h0,
            1, 32'h8000_0008, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 1, 32'h0);
    add_vec(32'h8000_0002, 3'd3, 4'b0000, 32'h0, 1, 5'd6, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0, 32'h0);
    add_vec(32'h8000_0001, 3'd0, 4'b0011, 32'h0000_FFFF, 1, 5'd6, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0, 32'h0);
    add_vec(32'h8000_0003, 3'd2, 4'b0000, 32'h0, 1, 5'd6, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0, 32'h0);
    add_vec(32'h8000_0006, 3'd0, 4'b1111, 32'h1111_2222, 1, 5'd6, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0, 32'h0);
    add_vec(32'h8000_0001, 3'd4, 4'b1111, 32'h1234_5678, 1, 5'd9, 32'h0000_AA00,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_00AA);
    add_vec(32'hCAFE_0001, 3'd6, 4'b0000, 32'h0, 1, 5'd8, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 0, 1, 1, 32'hCAFE_0001);
    add_vec(32'h0000_0077, 3'd0, 4'b0010, 32'h0000_00FF, 1, 5'd8, 32'h0,
            0, 32'h0, 0, 4'b0000, 32'h0, 0, 1, 1, 32'h0000_0077);
    add_vec(32'h8000_0000, 3'd1, 4'b0000, 32'h0, 1, 5'd0, 32'h0000_007F,
            1, 32'h8000_0000, 0, 4'b0000, 32'h0, 0, 0, 1, 32'h0000_007F);

    // Reset with a valid operation presented: reset must win.
    rst = 1'b1; in_valid = 1'b1; alu_result = 32'h8000_0000; load_inst = 3'd3;
    store_mask = 4'b0000; store_data = 32'h0; d_regW = 1'b1; d_regAddr = 5'd3;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0; alu_result = '0; load_inst = '0; d_regW = 1'b0;
    d_regAddr = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0; out_ready = 1'b0;
    chk_reset("rst0");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // lw with request stall, delayed response and write-back backpressure.
    drive_op(32'h8000_0010, 3'd3, 4'b0000, 32'h0, 1'b1, 5'd3);
    for (int c = 0; c < 3; c++) begin
      chkb($sformatf("stall%0d_req_valid", c), mem_req_valid, 1'b1);
      chk($sformatf("stall%0d_req_addr", c), mem_req_addr, 32'h8000_0010);
      chkb($sformatf("stall%0d_req_wen", c), mem_req_wen, 1'b0);
      chk($sformatf("stall%0d_req_wmask", c), 32'(mem_req_wmask), 32'h0);
      chkb($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
      tick();
    end
    chkb("stall_req_valid_last", mem_req_valid, 1'b1);
    chk("stall_req_addr_last", mem_req_addr, 32'h8000_0010);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chkb($sformatf("wait%0d_out_valid", c), out_valid, 1'b0);
      chkb($sformatf("wait%0d_req_valid", c), mem_req_valid, 1'b0);
      chkb($sformatf("wait%0d_in_ready", c), in_ready, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1357_9BDF;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      chkb($sformatf("hold%0d_out_valid", c), out_valid, 1'b1);
      chk($sformatf("hold%0d_data", c), w_regData, 32'h1357_9BDF);
      chkb($sformatf("hold%0d_regW", c), w_regW, 1'b1);
      chk($sformatf("hold%0d_regAddr", c), 32'(w_regAddr), 32'd3);
      chkb($sformatf("hold%0d_in_ready", c), in_ready, 1'b0);
      if (c == 2) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chkb("hold_done_in_ready", in_ready, 1'b1);
    chkb("hold_done_out_valid", out_valid, 1'b0);

    // Response coinciding with the request handshake is not sampled.
    drive_op(32'h8000_0020, 3'd3, 4'b0000, 32'h0, 1'b1, 5'd4);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    chkb("coinc_out_valid", out_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h600D_F00D;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    chkb("coinc_out_valid2", out_valid, 1'b1);
    chk("coinc_data", w_regData, 32'h600D_F00D);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while waiting for the response; a late response is ignored.
    drive_op(32'h8000_0030, 3'd3, 4'b0000, 32'h0, 1'b1, 5'd9);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rstw");
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    chkb("stray_out_valid", out_valid, 1'b0);
    chkb("stray_in_ready", in_ready, 1'b1);
    chkb("stray_req_valid", mem_req_valid, 1'b0);
    chk("stray_regData", w_regData, 32'h0);
    run_vec(vecs[8], 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
